sumador_secuencial: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes an ANCHO-bit operand pair in ANCHO_DIGITO-bit slices, one slice per clock. It carries between slices through an internal carry register. It uses a start/busy/done handshake and produces the sum or difference, carry/borrow and signed overflow. It is the sequential, width-generic successor to the single-bit full-adder cell and sits between operand registers and result consumers in datapath blocks.

---
 rtl/sumador_pkg.sv | 20 ++
 rtl/sumador_digito.sv | 24 ++
 rtl/sumador_secuencial.sv | 158 +++++++++++++++
 tb/tb_sumador_secuencial.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared types and sizing helpers for the sliced sequential adder/subtractor.
package sumador_pkg;

  typedef enum logic {
    REPOSO  = 1'b0,
    CALCULO = 1'b1
  } estado_e;

  // Number of slices needed to cover the operand; zero-width slices yield 0.
  function automatic int unsigned num_digitos(input int unsigned ancho,
                                              input int unsigned ancho_digito);
    return (ancho_digito == 0) ? 32'd0 : ancho / ancho_digito;
  endfunction

  // Slice counter width, never narrower than one bit.
  function automatic int unsigned ancho_contador(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sumador_digito.sv
// Combinational ANCHO-bit ripple adder made of single-bit full-adder cells.
module sumador_digito #(
  parameter int unsigned ANCHO = 4
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             cin,
  output logic [ANCHO-1:0] s,
  output logic             cout
);

  logic acarreo;

  always_comb begin
    acarreo = cin;
    s       = '0;
    for (int i = 0; i < int'(ANCHO); i++) begin
      s[i]    = a[i] ^ b[i] ^ acarreo;
      acarreo = (a[i] & b[i]) | (acarreo & (a[i] ^ b[i]));
    end
    cout = acarreo;
  end

endmodule

// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: one ANCHO_DIGITO slice per clock, LSB slice first,
// with a start/busy/done handshake and registered result and flags.
module sumador_secuencial
  import sumador_pkg::*;
#(
  parameter int unsigned ANCHO        = 16,
  parameter int unsigned ANCHO_DIGITO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic             Resta,
  input  logic [ANCHO-1:0] X,
  input  logic [ANCHO-1:0] Y,
  input  logic             AcarreoEntrada,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] Salida,
  output logic             AcarreoSalida,
  output logic             Desbordamiento
);

  localparam int unsigned NUM_DIGITOS = num_digitos(ANCHO, ANCHO_DIGITO);
  localparam int unsigned ANCHO_CNT   = ancho_contador(NUM_DIGITOS);

  if ((ANCHO_DIGITO == 0) || (ANCHO_DIGITO > ANCHO) ||
      (ANCHO_DIGITO * NUM_DIGITOS != ANCHO)) begin : g_param_invalido
    $error("sumador_secuencial: ANCHO must be a positive multiple of ANCHO_DIGITO");
  end

  estado_e                 estado_q, estado_d;
  logic [ANCHO_CNT-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0]        xs_q, xs_d;
  logic [ANCHO-1:0]        ys_q, ys_d;
  logic [ANCHO-1:0]        res_q, res_d;
  logic                    x_msb_q, x_msb_d;
  logic                    y_msb_q, y_msb_d;
  logic                    acarreo_q, acarreo_d;
  logic                    ocupado_q, ocupado_d;
  logic                    listo_q, listo_d;
  logic [ANCHO-1:0]        salida_q, salida_d;
  logic                    acs_q, acs_d;
  logic                    desb_q, desb_d;

  logic [ANCHO_DIGITO-1:0] suma_c;
  logic                    acarreo_c;
  logic [ANCHO-1:0]        res_nuevo_c;
  logic                    ultimo_c;

  // Operands are shifted right each cycle so the active slice is always at bit 0.
  sumador_digito #(
    .ANCHO (ANCHO_DIGITO)
  ) u_digito (
    .a    (xs_q[ANCHO_DIGITO-1:0]),
    .b    (ys_q[ANCHO_DIGITO-1:0]),
    .cin  (acarreo_q),
    .s    (suma_c),
    .cout (acarreo_c)
  );

  // New slice enters the shadow result from the top; after the last slice it is aligned.
  assign res_nuevo_c = ANCHO'({suma_c, res_q} >> ANCHO_DIGITO);
  assign ultimo_c    = (cnt_q == ANCHO_CNT'(NUM_DIGITOS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= REPOSO;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      REPOSO:  if (inicio)   estado_d = CALCULO;
      CALCULO: if (ultimo_c) estado_d = REPOSO;
      default:               estado_d = REPOSO;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    res_d     = res_q;
    x_msb_d   = x_msb_q;
    y_msb_d   = y_msb_q;
    acarreo_d = acarreo_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    salida_d  = salida_q;
    acs_d     = acs_q;
    desb_d    = desb_q;
    unique case (estado_q)
      REPOSO: begin
        if (inicio) begin
          xs_d      = X;
          ys_d      = Resta ? ~Y : Y;
          x_msb_d   = X[ANCHO-1];
          y_msb_d   = Y[ANCHO-1] ^ Resta;
          acarreo_d = AcarreoEntrada ^ Resta;
          cnt_d     = '0;
          ocupado_d = 1'b1;
        end
      end
      CALCULO: begin
        xs_d      = xs_q >> ANCHO_DIGITO;
        ys_d      = ys_q >> ANCHO_DIGITO;
        res_d     = res_nuevo_c;
        acarreo_d = acarreo_c;
        cnt_d     = cnt_q + ANCHO_CNT'(1);
        if (ultimo_c) begin
          salida_d  = res_nuevo_c;
          acs_d     = acarreo_c;
          desb_d    = (x_msb_q == y_msb_q) && (res_nuevo_c[ANCHO-1] != x_msb_q);
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      res_q     <= '0;
      x_msb_q   <= 1'b0;
      y_msb_q   <= 1'b0;
      acarreo_q <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      salida_q  <= '0;
      acs_q     <= 1'b0;
      desb_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      res_q     <= res_d;
      x_msb_q   <= x_msb_d;
      y_msb_q   <= y_msb_d;
      acarreo_q <= acarreo_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      salida_q  <= salida_d;
      acs_q     <= acs_d;
      desb_q    <= desb_d;
    end
  end

  assign ocupado        = ocupado_q;
  assign listo          = listo_q;
  assign Salida         = salida_q;
  assign AcarreoSalida  = acs_q;
  assign Desbordamiento = desb_q;

endmodule

// File: tb/tb_sumador_secuencial.sv
// Scoreboard bench for sumador_secuencial: slice widths 4 (main), 16 and 1.
module tb_sumador_secuencial;

  localparam int unsigned ANCHO = 16;

  typedef struct packed {
    logic [1:0]       idx;
    logic [ANCHO-1:0] salida;
    logic             carry;
    logic             ovf;
  } res_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             resta;
  logic             cin;
  logic [ANCHO-1:0] x;
  logic [ANCHO-1:0] y;
  logic             inicio_v  [3];
  logic             ocupado_v [3];
  logic             listo_v   [3];
  logic             carry_v   [3];
  logic             ovf_v     [3];
  logic [ANCHO-1:0] salida_v  [3];

  res_t sb [$];
  int   checks  = 0;
  int   errores = 0;

  always #5 clk = ~clk;

  sumador_secuencial #(.ANCHO(ANCHO), .ANCHO_DIGITO(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio_v[0]), .Resta(resta), .X(x), .Y(y),
    .AcarreoEntrada(cin), .ocupado(ocupado_v[0]), .listo(listo_v[0]),
    .Salida(salida_v[0]), .AcarreoSalida(carry_v[0]), .Desbordamiento(ovf_v[0]));

  sumador_secuencial #(.ANCHO(ANCHO), .ANCHO_DIGITO(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio_v[1]), .Resta(resta), .X(x), .Y(y),
    .AcarreoEntrada(cin), .ocupado(ocupado_v[1]), .listo(listo_v[1]),
    .Salida(salida_v[1]), .AcarreoSalida(carry_v[1]), .Desbordamiento(ovf_v[1]));

  sumador_secuencial #(.ANCHO(ANCHO), .ANCHO_DIGITO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio_v[2]), .Resta(resta), .X(x), .Y(y),
    .AcarreoEntrada(cin), .ocupado(ocupado_v[2]), .listo(listo_v[2]),
    .Salida(salida_v[2]), .AcarreoSalida(carry_v[2]), .Desbordamiento(ovf_v[2]));

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: obtenido %0h esperado %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic res_t esp(input logic [1:0] i, input logic [ANCHO-1:0] s,
                               input logic c, input logic o);
    res_t r;
    r.idx    = i;
    r.salida = s;
    r.carry  = c;
    r.ovf    = o;
    return r;
  endfunction

  // Reference from integer arithmetic: unsigned value for result/carry, signed for overflow.
  function automatic res_t modelo(input logic [1:0] i, input logic r, input logic [ANCHO-1:0] a,
                                  input logic [ANCHO-1:0] b, input logic ci);
    int u;
    int v;
    if (r) begin
      u = int'(a) - int'(b) - int'(ci);
      v = int'($signed(a)) - int'($signed(b)) - int'(ci);
      return esp(i, 16'(u), u >= 0, (v > 32767) || (v < -32768));
    end
    u = int'(a) + int'(b) + int'(ci);
    v = int'($signed(a)) + int'($signed(b)) + int'(ci);
    return esp(i, 16'(u), u > 65535, (v > 32767) || (v < -32768));
  endfunction

  task automatic revisar(input logic [1:0] idx);
    res_t e;
    if (listo_v[idx] === 1'b1) begin
      if (sb.size() == 0) begin
        chequear("listo_espurio", 32'(listo_v[idx]), 32'd0);
      end else begin
        e = sb.pop_front();
        chequear("instancia",      32'(idx),           32'(e.idx));
        chequear("Salida",         32'(salida_v[idx]), 32'(e.salida));
        chequear("AcarreoSalida",  32'(carry_v[idx]),  32'(e.carry));
        chequear("Desbordamiento", 32'(ovf_v[idx]),    32'(e.ovf));
      end
    end
  endtask

  always @(negedge clk) begin
    revisar(2'd0);
    revisar(2'd1);
    revisar(2'd2);
  end

  // Called on a falling edge; returns on the falling edge after the start was sampled.
  task automatic arrancar(input logic [1:0] idx, input logic r, input logic [ANCHO-1:0] a,
                          input logic [ANCHO-1:0] b, input logic ci, input res_t e);
    resta = r;
    x     = a;
    y     = b;
    cin   = ci;
    inicio_v[idx] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    inicio_v[idx] = 1'b0;
  endtask

  task automatic esperar_vacio();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chequear("scoreboard_vacio", 32'(sb.size()), 32'd0);
  endtask

  task automatic operar(input logic [1:0] idx, input logic r, input logic [ANCHO-1:0] a,
                        input logic [ANCHO-1:0] b, input logic ci, input res_t e);
    arrancar(idx, r, a, b, ci, e);
    esperar_vacio();
  endtask

  task automatic operar_medido(input logic [1:0] idx, input logic r, input logic [ANCHO-1:0] a,
                               input logic [ANCHO-1:0] b, input logic ci, input res_t e,
                               input int lat);
    logic [ANCHO-1:0] previo;
    int ciclos;
    previo = salida_v[idx];
    arrancar(idx, r, a, b, ci, e);
    ciclos = 0;
    while (ocupado_v[idx] === 1'b1 && ciclos < 64) begin
      if (ciclos == lat / 2) chequear("salida_estable", 32'(salida_v[idx]), 32'(previo));
      ciclos++;
      @(negedge clk);
    end
    chequear("ciclos_ocupado", 32'(ciclos), 32'(lat));
    chequear("listo_pulso", 32'(listo_v[idx]), 32'd1);
    @(negedge clk);
    chequear("listo_un_ciclo", 32'(listo_v[idx]), 32'd0);
  endtask

  initial begin
    logic             r;
    logic             ci;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    int               t;

    for (int i = 0; i < 3; i++) inicio_v[i] = 1'b0;
    resta = 1'b0;
    cin   = 1'b0;
    x     = '0;
    y     = '0;
    #1 rst_n = 1'b0;

    // Reset with random inputs
    repeat (4) begin
      @(negedge clk);
      x           = 16'($urandom);
      y           = 16'($urandom);
      resta       = 1'($urandom);
      cin         = 1'($urandom);
      inicio_v[0] = 1'($urandom);
    end
    chequear("reset_ocupado", 32'(ocupado_v[0]), 32'd0);
    chequear("reset_listo",   32'(listo_v[0]),   32'd0);
    chequear("reset_Salida",  32'(salida_v[0]),  32'd0);
    chequear("reset_carry",   32'(carry_v[0]),   32'd0);
    chequear("reset_ovf",     32'(ovf_v[0]),     32'd0);
    inicio_v[0] = 1'b0;
    rst_n       = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chequear("reposo_ocupado", 32'(ocupado_v[0]), 32'd0);
    end

    operar_medido(2'd0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, esp(2'd0, 16'h2233, 1'b0, 1'b0), 4);

    operar(2'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, esp(2'd0, 16'h0000, 1'b1, 1'b0));
    operar(2'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, esp(2'd0, 16'h8000, 1'b0, 1'b1));
    operar(2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, esp(2'd0, 16'hFFFF, 1'b1, 1'b0));
    operar(2'd0, 1'b1, 16'h0005, 16'h0007, 1'b0, esp(2'd0, 16'hFFFE, 1'b0, 1'b0));
    operar(2'd0, 1'b1, 16'h8000, 16'h0001, 1'b0, esp(2'd0, 16'h7FFF, 1'b1, 1'b1));
    operar(2'd0, 1'b1, 16'h0010, 16'h0001, 1'b1, esp(2'd0, 16'h000E, 1'b1, 1'b0));

    // Start pulsed again mid-computation must be ignored
    resta       = 1'b0;
    x           = 16'h1111;
    y           = 16'h2222;
    cin         = 1'b0;
    inicio_v[0] = 1'b1;
    sb.push_back(esp(2'd0, 16'h3333, 1'b0, 1'b0));
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 1) inicio_v[0] = 1'b0;
      if (t == 2) begin
        resta       = 1'b1;
        x           = 16'hAAAA;
        y           = 16'h5555;
        cin         = 1'b1;
        inicio_v[0] = 1'b1;
      end
      if (t == 3) inicio_v[0] = 1'b0;
    end while (listo_v[0] !== 1'b1 && t < 40);
    chequear("latencia_inicio_ignorado", 32'(t), 32'd5);
    // Back-to-back start in the listo cycle
    operar_medido(2'd0, 1'b1, 16'h0100, 16'h0001, 1'b0, esp(2'd0, 16'h00FF, 1'b1, 1'b0), 4);

    // Reset during the third compute cycle aborts without listo
    resta       = 1'b0;
    x           = 16'h4321;
    y           = 16'h1111;
    cin         = 1'b0;
    inicio_v[0] = 1'b1;
    @(negedge clk);
    inicio_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chequear("abortar_ocupado", 32'(ocupado_v[0]), 32'd0);
    chequear("abortar_listo",   32'(listo_v[0]),   32'd0);
    chequear("abortar_Salida",  32'(salida_v[0]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chequear("sin_listo_tras_abortar", 32'(listo_v[0]), 32'd0);
    end
    operar_medido(2'd0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, esp(2'd0, 16'h2233, 1'b0, 1'b0), 4);

    operar_medido(2'd1, 1'b0, 16'h1234, 16'h0FFF, 1'b0, esp(2'd1, 16'h2233, 1'b0, 1'b0), 1);
    operar_medido(2'd2, 1'b0, 16'h1234, 16'h0FFF, 1'b0, esp(2'd2, 16'h2233, 1'b0, 1'b0), 16);

    repeat (12) begin
      r  = 1'($urandom);
      ci = 1'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      operar(2'd0, r, a, b, ci, modelo(2'd0, r, a, b, ci));
    end
    repeat (4) begin
      r  = 1'($urandom);
      ci = 1'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      operar(2'd1, r, a, b, ci, modelo(2'd1, r, a, b, ci));
      operar(2'd2, r, a, b, ci, modelo(2'd2, r, a, b, ci));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: obtenido timeout esperado fin");
    $fatal(1, "watchdog");
  end

endmodule
